// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one external combinational 32-bit ALU between two requesters.
// Requests are arbitrated round-robin in IDLE. The operands are latched, and
// the operation runs in one of two ways:
//   - a single ALU pass (EXEC) for ALU select codes 0-7
//   - a shift-add multiply (MUL) that iterates the ALU add function
// The result, flags and requester id are registered into a single response
// channel (RESP). Priority flips to the other requester only when a response
// is consumed.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   rN_valid / rN_ready    requester N handshake (ready is combinational)
//   rN_op, rN_a, rN_b      opcode (0-7 ALU select, 8 multiply, 9-15 illegal)
//                          and the two operands
//   rsp_valid / rsp_ready  response handshake
//   rsp_id                 requester that issued the operation
//   rsp_result             registered result
//   rsp_v, rsp_z           registered overflow and zero flags
//   rsp_err                set for an illegal opcode
//   alu_a, alu_b, alu_s    operands and select driven to the external ALU
//   alu_result             result returned by the external ALU
//   alu_v, alu_z           overflow and zero flags returned by the ALU
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
  parameter int MUL_STEPS = 32,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [3:0]  r0_op,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [3:0]  r1_op,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_v,
  output logic        rsp_z,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_s,
  input  logic [31:0] alu_result,
  input  logic        alu_v,
  input  logic        alu_z
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_STEPS);

  state_t      state_r;
  state_t      state_nxt_s;

  logic        prio_r;
  logic        id_r;
  logic [2:0]  sel_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] acc_r;
  logic [31:0] mcand_r;
  logic [31:0] mplier_r;
  logic [5:0]  cnt_r;

  logic        grant_s;
  logic        accept_s;
  logic [3:0]  gop_s;
  logic [31:0] ga_s;
  logic [31:0] gb_s;

  // Arbitration: a single requester wins outright, and a tie goes to prio_r.
  always_comb begin
    grant_s = prio_r;
    if (r0_valid && !r1_valid) begin
      grant_s = 1'b0;
    end else if (r1_valid && !r0_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = prio_r;
    end
    accept_s = (state_r == IDLE) && (r0_valid || r1_valid);
    r0_ready = accept_s && !grant_s && r0_valid;
    r1_ready = accept_s && grant_s && r1_valid;
    if (grant_s) begin
      gop_s = r1_op;
      ga_s  = r1_a;
      gb_s  = r1_b;
    end else begin
      gop_s = r0_op;
      ga_s  = r0_a;
      gb_s  = r0_b;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. MUL stays for MUL_STEPS shift-add cycles plus one final
  // cycle that hands the settled accumulator to the response registers.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (gop_s < 4'd8) begin
            state_nxt_s = EXEC;
          end else if (gop_s == 4'd8) begin
            state_nxt_s = MUL;
          end else begin
            state_nxt_s = RESP;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      MUL: begin
        if (cnt_r == MUL_LAST) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = MUL;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // ALU drive: the latched operands in EXEC, accumulator + multiplicand with
  // add in MUL, and zero in every other state.
  always_comb begin
    alu_a = 32'd0;
    alu_b = 32'd0;
    alu_s = 3'b000;
    case (state_r)
      EXEC: begin
        alu_a = a_r;
        alu_b = b_r;
        alu_s = sel_r;
      end
      MUL: begin
        alu_a = acc_r;
        alu_b = mcand_r;
        alu_s = 3'b010;
      end
      default: begin
        alu_a = 32'd0;
        alu_b = 32'd0;
        alu_s = 3'b000;
      end
    endcase
  end

  // Datapath: operand latch, multiply iteration, response registers, priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_r     <= INIT_PRIO;
      id_r       <= 1'b0;
      sel_r      <= 3'd0;
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      acc_r      <= 32'd0;
      mcand_r    <= 32'd0;
      mplier_r   <= 32'd0;
      cnt_r      <= 6'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 32'd0;
      rsp_v      <= 1'b0;
      rsp_z      <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            id_r     <= grant_s;
            sel_r    <= gop_s[2:0];
            a_r      <= ga_s;
            b_r      <= gb_s;
            acc_r    <= 32'd0;
            mcand_r  <= ga_s;
            mplier_r <= gb_s;
            cnt_r    <= 6'd0;
            // An illegal opcode skips execution and responds straight away.
            if (gop_s > 4'd8) begin
              rsp_valid  <= 1'b1;
              rsp_id     <= grant_s;
              rsp_result <= 32'd0;
              rsp_v      <= 1'b0;
              rsp_z      <= 1'b0;
              rsp_err    <= 1'b1;
            end
          end
        end
        EXEC: begin
          rsp_valid  <= 1'b1;
          rsp_id     <= id_r;
          rsp_result <= alu_result;
          rsp_v      <= alu_v;
          rsp_z      <= alu_z;
          rsp_err    <= 1'b0;
        end
        MUL: begin
          if (cnt_r != MUL_LAST) begin
            if (mplier_r[0]) begin
              acc_r <= alu_result;
            end
            mcand_r  <= {mcand_r[30:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[31:1]};
            cnt_r    <= cnt_r + 6'd1;
          end else begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_r;
            rsp_result <= acc_r;
            rsp_v      <= 1'b0;
            rsp_z      <= (acc_r == 32'd0);
            rsp_err    <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            prio_r    <= ~rsp_id;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer/arbiter that shares one external 32-bit ALU (and/or/add/xor/sub/srl/sll/nor, V and Z flags) between two requesters.
- Requesters use a valid/ready handshake. The block performs round-robin arbitration, latches operands, drives the ALU select and operand lines, and registers the result into a shared response channel.
- Also sequences a multi-cycle 32x32->32 (low word) multiply by iterating the ALU add function.

Parameters:
- MUL_STEPS, 32, number of shift-add iterations for multiply; must be 1..32.
- INIT_PRIO, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- r0_valid  input  1  requester 0 has an operation.
- r0_ready  output  1  requester 0 operation accepted this cycle.
- r0_op  input  4  operation code: 0-7 = ALU select code, 8 = multiply, 9-15 illegal.
- r0_a  input  32  operand A.
- r0_b  input  32  operand B.
- r1_valid, r1_ready, r1_op, r1_a, r1_b: same as requester 0, for requester 1.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  requester that issued the operation.
- rsp_result  output  32  result.
- rsp_v  output  1  overflow flag.
- rsp_z  output  1  zero flag.
- rsp_err  output  1  illegal opcode.
- alu_a  output  32  ALU operand A.
- alu_b  output  32  ALU operand B.
- alu_s  output  3  ALU select.
- alu_result  input  32  ALU result (combinational from alu_a, alu_b, alu_s).
- alu_v  input  1  ALU overflow.
- alu_z  input  1  ALU zero.

Behaviour:
- States: IDLE, EXEC, MUL, RESP.
- Reset: state=IDLE; all outputs 0 (r*_ready, rsp_*, alu_a, alu_b, alu_s); prio=INIT_PRIO; iteration counter 0. Reset overrides any state, including mid-MUL or RESP; an in-flight operation is discarded with no response.
- IDLE arbitration:
  - Only r0_valid: grant 0. Only r1_valid: grant 1. Both: grant prio.
  - rN_ready is combinational: high only in IDLE, only for the granted requester, and only when that requester's valid is high.
  - On accept, latch op, a, b and id.
  - Next state: op 0-7 -> EXEC; op 8 -> MUL; op 9-15 -> RESP with result=0, v=0, z=0, err=1.
- EXEC (1 cycle):
  - alu_a=latched A, alu_b=latched B, alu_s=op[2:0].
  - At the clock edge capture result<=alu_result, v<=alu_v, z<=alu_z, err<=0; go to RESP.
- MUL:
  - acc=0, mcand=A, mplier=B at entry.
  - Each cycle: alu_a=acc, alu_b=mcand, alu_s=010. If mplier[0]=1 then acc<=alu_result, else acc holds.
  - Locally, mcand<<=1 and mplier>>=1 (logical, zero fill); counter increments.
  - After MUL_STEPS cycles go to RESP with result=acc, v=0, z=(acc==0), err=0.
  - Overflow beyond 32 bits is discarded; alu_v is ignored during multiply.
- RESP:
  - rsp_valid=1; rsp_* outputs are registers, stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_ready=1: go to IDLE; prio <= ~rsp_id; rsp_valid drops next cycle.
- Outside EXEC/MUL: alu_a=0, alu_b=0, alu_s=000.
- Latency:
  - ALU op: accept edge T, rsp_valid high at T+2.
  - Multiply: rsp_valid high at T+1+MUL_STEPS+1.
  - Illegal op: rsp_valid high at T+1.
- Back-to-back: no new accept while busy. The earliest next accept is the cycle after the rsp_ready handshake, so there is one idle cycle minimum between operations.
- Priority updates only on response completion, not on accept.

Test Plan:
- After reset, r0: op=2, a=0x7FFFFFFF, b=1 -> r0_ready pulses 1 cycle; 2 cycles later rsp_valid=1, rsp_result=0x80000000, rsp_v=1, rsp_z=0, rsp_id=0.
- r1: op=4, a=5, b=5 with rsp_ready=0 for 3 cycles -> rsp_result=0, rsp_z=1, rsp_v=0; outputs stable until rsp_ready=1; rsp_valid drops the next cycle.
- Both requesters valid continuously (r0 op=0 a=0xF0F0 b=0xFF00, r1 op=7 a=0 b=0), INIT_PRIO=0 -> grants alternate 0,1,0,1; responses 0x0000F000 then 0xFFFFFFFF.
- r0: op=8, a=1234, b=5678 -> rsp_result=7006652 at accept+34 cycles, rsp_v=0; also a=0x10000, b=0x10000 -> rsp_result=0, rsp_z=1.
- r1: op=12 -> rsp_err=1, rsp_result=0 at accept+1; r1 op=6 a=1 b=31 -> rsp_result=0x80000000.
- Reset asserted during MUL cycle 10 -> next cycle state IDLE, rsp_valid=0, alu_s=0, prio=INIT_PRIO; no response is ever produced for the aborted operation.
